// File: rtl/pp_seq_core_p.sv
`default_nettype none
// ============================================================================
// Module   : pp_seq_core_p
// Brief    : Pulse-sequencer core (TTL lines, delays, trigger waits, loops,
//            PMT gating). Optional single-step: PPSEQ_DEBUG_STEP_EN.
// Revision : 1.0
// ============================================================================
module pp_seq_core_p #(
    parameter int ADDR_W     = 16,
    parameter int DO_WIDTH   = 8,
    parameter int CNT_W      = 32,
    parameter int LOOP_DEPTH = 4
) (
    input  logic                wClk_i,
    input  logic                wReset_i,
    input  logic [ADDR_W-1:0]   wStartAddr_i,
    input  logic                wStartTrig_i,
    input  logic                wStopTrig_i,
`ifdef PPSEQ_DEBUG_STEP_EN
    input  logic                wDebug_i,
    input  logic                wStepTrig_i,
`endif
    output logic                wBusy_o,
    output logic [1:0]          wErr_o,
    output logic [ADDR_W-1:0]   wMemAddr_o,
    input  logic [31:0]         wMem_i,
    output logic [31:0]         wMem_o,
    output logic                wMemWE_o,
    input  logic                wLineTrig_i,
    input  logic                wPMT_i,
    output logic [DO_WIDTH-1:0] rDO_o,
    output logic                rTimeout_o,
    output logic [ADDR_W-1:0]   wPC_o
);

    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int STK_N = 2 ** IDX_W;

    localparam logic [7:0] c_OP_NOP   = 8'h00;
    localparam logic [7:0] c_OP_SETDO = 8'h01;
    localparam logic [7:0] c_OP_DELAY = 8'h02;
    localparam logic [7:0] c_OP_WAITL = 8'h03;
    localparam logic [7:0] c_OP_LOOP  = 8'h04;
    localparam logic [7:0] c_OP_ENDL  = 8'h05;
    localparam logic [7:0] c_OP_COUNT = 8'h06;
    localparam logic [7:0] c_OP_STW   = 8'h07;
    localparam logic [7:0] c_OP_JMP   = 8'h10;
    localparam logic [7:0] c_OP_STOP  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WK_DELAY = 2'd0,
        WK_LINE  = 2'd1,
        WK_COUNT = 2'd2,
        WK_STEP  = 2'd3
    } wkind_t;

    state_t              state_q, state_d;
    wkind_t              wkind_q, wkind_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    w_q, w_d;
    logic [DO_WIDTH-1:0] do_q, do_d;
    logic [1:0]          err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [23:0]         wcnt_q, wcnt_d;
    logic                wtimed_q, wtimed_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [ADDR_W-1:0]   stk_addr_q [STK_N];
    logic [ADDR_W-1:0]   stk_addr_d [STK_N];
    logic [23:0]         stk_cnt_q  [STK_N];
    logic [23:0]         stk_cnt_d  [STK_N];

    logic [7:0]          op;
    logic [23:0]         arg;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    push_idx;
    logic                stk_full;
    logic                done;
    logic                step_hold;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;

    assign op       = wMem_i[31:24];
    assign arg      = wMem_i[23:0];
    assign top_idx  = IDX_W'(sp_q - 1'b1);
    assign push_idx = IDX_W'(sp_q);
    assign stk_full = (sp_q == SP_W'(LOOP_DEPTH));

`ifdef PPSEQ_DEBUG_STEP_EN
    assign step_hold = wDebug_i;
`else
    assign step_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wkind_d    = wkind_q;
        pc_d       = pc_q;
        w_d        = w_q;
        do_d       = do_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        wcnt_d     = wcnt_q;
        wtimed_d   = wtimed_q;
        sp_d       = sp_q;
        stk_addr_d = stk_addr_q;
        stk_cnt_d  = stk_cnt_q;
        mem_addr   = pc_q;
        mem_we     = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_d = wStartAddr_i;
                if (wStartTrig_i) begin
                    state_d = S_FETCH;
                    w_d     = '0;
                    err_d   = 2'b00;
                    tmo_d   = 1'b0;
                    sp_d    = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                pc_d = pc_q + 1'b1;
                case (op)
                    c_OP_NOP: done = 1'b1;
                    c_OP_SETDO: begin
                        do_d = arg[DO_WIDTH-1:0];
                        done = 1'b1;
                    end
                    c_OP_DELAY: begin
                        // Fetch+decode already account for two cycles
                        if (arg > 24'd2) begin
                            state_d = S_WAIT;
                            wkind_d = WK_DELAY;
                            wcnt_d  = arg - 24'd2;
                        end else begin
                            done = 1'b1;
                        end
                    end
                    c_OP_WAITL: begin
                        state_d  = S_WAIT;
                        wkind_d  = WK_LINE;
                        wcnt_d   = arg;
                        wtimed_d = (arg != 24'd0);
                    end
                    c_OP_LOOP: begin
                        if (stk_full) begin
                            err_d   = 2'b01;
                            state_d = S_IDLE;
                        end else begin
                            stk_addr_d[push_idx] = pc_q + 1'b1;
                            stk_cnt_d[push_idx]  = (arg == 24'd0) ? 24'd0 : arg - 24'd1;
                            sp_d = sp_q + 1'b1;
                            done = 1'b1;
                        end
                    end
                    c_OP_ENDL: begin
                        if (sp_q == '0) begin
                            err_d   = 2'b10;
                            state_d = S_IDLE;
                        end else begin
                            if (stk_cnt_q[top_idx] != 24'd0) begin
                                stk_cnt_d[top_idx] = stk_cnt_q[top_idx] - 24'd1;
                                pc_d = stk_addr_q[top_idx];
                            end else begin
                                sp_d = sp_q - 1'b1;
                            end
                            done = 1'b1;
                        end
                    end
                    c_OP_COUNT: begin
                        w_d     = '0;
                        state_d = S_WAIT;
                        wkind_d = WK_COUNT;
                        wcnt_d  = (arg == 24'd0) ? 24'd1 : arg;
                    end
                    c_OP_STW: begin
                        mem_addr = ADDR_W'(arg);
                        mem_we   = 1'b1;
                        done     = 1'b1;
                    end
                    c_OP_JMP: begin
                        pc_d = ADDR_W'(arg);
                        done = 1'b1;
                    end
                    c_OP_STOP: state_d = S_IDLE;
                    default: begin
                        err_d   = 2'b11;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                case (wkind_q)
                    WK_DELAY: begin
                        if (wcnt_q == 24'd1) done = 1'b1;
                        else wcnt_d = wcnt_q - 24'd1;
                    end
                    WK_LINE: begin
                        // Trigger takes priority over the final timeout cycle
                        if (wLineTrig_i) begin
                            done = 1'b1;
                        end else if (wtimed_q) begin
                            if (wcnt_q == 24'd1) begin
                                tmo_d = 1'b1;
                                done  = 1'b1;
                            end else begin
                                wcnt_d = wcnt_q - 24'd1;
                            end
                        end
                    end
                    WK_COUNT: begin
                        if (wPMT_i && (w_q != {CNT_W{1'b1}})) w_d = w_q + 1'b1;
                        if (wcnt_q == 24'd1) done = 1'b1;
                        else wcnt_d = wcnt_q - 24'd1;
                    end
                    WK_STEP: begin
`ifdef PPSEQ_DEBUG_STEP_EN
                        if (wStepTrig_i) state_d = S_FETCH;
`else
                        state_d = S_FETCH;
`endif
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            if (step_hold) begin
                state_d = S_WAIT;
                wkind_d = WK_STEP;
            end else begin
                state_d = S_FETCH;
            end
        end

        // Abort discards the in-flight instruction's side effects
        if (wStopTrig_i) begin
            state_d    = S_IDLE;
            w_d        = w_q;
            do_d       = do_q;
            err_d      = err_q;
            tmo_d      = tmo_q;
            sp_d       = sp_q;
            stk_addr_d = stk_addr_q;
            stk_cnt_d  = stk_cnt_q;
            mem_addr   = pc_q;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge wClk_i or posedge wReset_i) begin
        if (wReset_i) begin
            state_q    <= S_IDLE;
            wkind_q    <= WK_DELAY;
            pc_q       <= '0;
            w_q        <= '0;
            do_q       <= '0;
            err_q      <= 2'b00;
            tmo_q      <= 1'b0;
            wcnt_q     <= '0;
            wtimed_q   <= 1'b0;
            sp_q       <= '0;
            stk_addr_q <= '{default: '0};
            stk_cnt_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wkind_q    <= wkind_d;
            pc_q       <= pc_d;
            w_q        <= w_d;
            do_q       <= do_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            wcnt_q     <= wcnt_d;
            wtimed_q   <= wtimed_d;
            sp_q       <= sp_d;
            stk_addr_q <= stk_addr_d;
            stk_cnt_q  <= stk_cnt_d;
        end
    end

    assign wBusy_o    = (state_q != S_IDLE);
    assign wErr_o     = err_q;
    assign wMemAddr_o = mem_addr;
    assign wMem_o     = 32'(w_q);
    assign wMemWE_o   = mem_we;
    assign rDO_o      = do_q;
    assign rTimeout_o = tmo_q;
    assign wPC_o      = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_seq_core_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_seq_core_p
// Brief    : Directed scoreboard bench for pp_seq_core_p (main + small-config).
// Revision : 1.0
// ============================================================================
module tb_pp_seq_core_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] start_addr;
    logic        start, stop, line_trig, pmt;
    logic        busy, we, tmo;
    logic [1:0]  err;
    logic [15:0] mem_addr, pc;
    logic [31:0] mem_rdata, mem_wdata;
    logic [7:0]  rdo;

    logic        start2, stop2, pmt2;
    logic        busy2, we2, tmo2;
    logic [1:0]  err2;
    logic [15:0] mem_addr2, pc2;
    logic [31:0] mem_rdata2, mem_wdata2;
    logic [7:0]  rdo2;

    logic        dbg, step;

    logic [31:0] ram  [0:65535];
    logic [31:0] ram2 [0:65535];

    always #5 clk = ~clk;

    pp_seq_core_p dut (
        .wClk_i(clk), .wReset_i(rst), .wStartAddr_i(start_addr),
        .wStartTrig_i(start), .wStopTrig_i(stop),
`ifdef PPSEQ_DEBUG_STEP_EN
        .wDebug_i(dbg), .wStepTrig_i(step),
`endif
        .wBusy_o(busy), .wErr_o(err), .wMemAddr_o(mem_addr), .wMem_i(mem_rdata),
        .wMem_o(mem_wdata), .wMemWE_o(we), .wLineTrig_i(line_trig), .wPMT_i(pmt),
        .rDO_o(rdo), .rTimeout_o(tmo), .wPC_o(pc)
    );

    pp_seq_core_p #(.ADDR_W(16), .DO_WIDTH(8), .CNT_W(4), .LOOP_DEPTH(1)) dut2 (
        .wClk_i(clk), .wReset_i(rst), .wStartAddr_i(16'h0000),
        .wStartTrig_i(start2), .wStopTrig_i(stop2),
`ifdef PPSEQ_DEBUG_STEP_EN
        .wDebug_i(1'b0), .wStepTrig_i(1'b0),
`endif
        .wBusy_o(busy2), .wErr_o(err2), .wMemAddr_o(mem_addr2), .wMem_i(mem_rdata2),
        .wMem_o(mem_wdata2), .wMemWE_o(we2), .wLineTrig_i(1'b0), .wPMT_i(pmt2),
        .rDO_o(rdo2), .rTimeout_o(tmo2), .wPC_o(pc2)
    );

    always @(posedge clk) begin
        if (we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (we2) ram2[mem_addr2] <= mem_wdata2;
        mem_rdata2 <= ram2[mem_addr2];
    end

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         wr2_q[$];
    logic [10:0] end_q[$];
    logic [10:0] end2_q[$];

    int checks   = 0;
    int failures = 0;

    int         trig_at = -1;
    int         pmt_lo  = -1;
    int         pmt_hi  = -2;
    logic [7:0] track   = 8'h00;
    int         n_cyc, n_hi, n_rise;

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [23:0] arg);
        return {op, arg};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever a DUT writes RAM or finishes
    initial begin
        logic b1 = 1'b0;
        logic b2 = 1'b0;
        wr_t  we_x;
        logic [10:0] ee_x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (we) begin
                    if (wr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL stw_unexpected: write addr=0x%0h data=0x%0h, required none", mem_addr, mem_wdata);
                    end else begin
                        we_x = wr_q.pop_front();
                        chk("stw_addr", mem_addr, we_x.a);
                        chk("stw_data", mem_wdata, we_x.d);
                    end
                end
                if (b1 && !busy) begin
                    if (end_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL end_unexpected: err=%0d tmo=%0d do=0x%0h, required no stop", err, tmo, rdo);
                    end else begin
                        ee_x = end_q.pop_front();
                        chk("end_err_tmo_do", {err, tmo, rdo}, ee_x);
                    end
                end
                if (we2) begin
                    if (wr2_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL stw2_unexpected: write addr=0x%0h data=0x%0h, required none", mem_addr2, mem_wdata2);
                    end else begin
                        we_x = wr2_q.pop_front();
                        chk("stw2_addr", mem_addr2, we_x.a);
                        chk("stw2_data", mem_wdata2, we_x.d);
                    end
                end
                if (b2 && !busy2) begin
                    if (end2_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL end2_unexpected: err=%0d, required no stop", err2);
                    end else begin
                        ee_x = end2_q.pop_front();
                        chk("end2_err_tmo_do", {err2, tmo2, rdo2}, ee_x);
                    end
                end
            end
            b1 = busy;
            b2 = busy2;
        end
    end

    task automatic go(input logic [15:0] addr, input int limit);
        int   i;
        logic p0;
        @(negedge clk);
        start_addr = addr;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        i      = 0;
        n_hi   = 0;
        n_rise = 0;
        p0     = rdo[0];
        while (busy && i < limit) begin
            line_trig = (trig_at >= 0 && i >= trig_at);
            pmt       = (i >= pmt_lo && i <= pmt_hi);
            if (rdo == track) n_hi++;
            if (rdo[0] && !p0) n_rise++;
            p0 = rdo[0];
            i++;
            @(negedge clk);
        end
        line_trig = 1'b0;
        pmt       = 1'b0;
        n_cyc     = i;
        if (busy) begin
            checks++; failures++;
            $display("FAIL run_bound: still busy after %0d cycles, required idle", limit);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 16'h0000;
        line_trig = 1'b0; pmt = 1'b0; start2 = 1'b0; stop2 = 1'b0; pmt2 = 1'b0;
        dbg = 1'b0; step = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]  = 32'h0;
            ram2[a] = 32'h0;
        end
        ram[16'h0000] = ins(8'h01, 24'h5A);  ram[16'h0001] = ins(8'h02, 24'd10);
        ram[16'h0002] = ins(8'h01, 24'h00);  ram[16'h0003] = ins(8'hFF, 24'h0);
        ram[16'h0010] = ins(8'h04, 24'd3);   ram[16'h0011] = ins(8'h04, 24'd2);
        ram[16'h0012] = ins(8'h01, 24'h01);  ram[16'h0013] = ins(8'h01, 24'h00);
        ram[16'h0014] = ins(8'h05, 24'h0);   ram[16'h0015] = ins(8'h05, 24'h0);
        ram[16'h0016] = ins(8'hFF, 24'h0);
        for (int a = 16'h20; a < 16'h25; a++) ram[a] = ins(8'h04, 24'd1);
        ram[16'h0030] = ins(8'h03, 24'd20);  ram[16'h0031] = ins(8'hFF, 24'h0);
        ram[16'h0040] = ins(8'h06, 24'd100); ram[16'h0041] = ins(8'h07, 24'h200);
        ram[16'h0042] = ins(8'hFF, 24'h0);
        ram[16'h0050] = ins(8'h02, 24'd2);   ram[16'h0051] = ins(8'h02, 24'd0);
        ram[16'h0052] = ins(8'h02, 24'd3);   ram[16'h0053] = ins(8'hFF, 24'h0);
        ram[16'h0060] = ins(8'h10, 24'h70);  ram[16'h0061] = ins(8'h01, 24'hFF);
        ram[16'h0070] = ins(8'hFF, 24'h0);
        ram[16'h0080] = ins(8'h01, 24'h3C);  ram[16'h0081] = ins(8'h02, 24'd1000);
        ram[16'h0090] = ins(8'h05, 24'h0);
        ram[16'h00A0] = ins(8'h7E, 24'h0);
        ram[16'h00A8] = ins(8'hFF, 24'h0);
        ram[16'h00B3] = ins(8'hFF, 24'h0);
        ram2[16'h0000] = ins(8'h06, 24'd30); ram2[16'h0001] = ins(8'h07, 24'h005);
        ram2[16'h0002] = ins(8'h04, 24'd2);  ram2[16'h0003] = ins(8'h04, 24'd2);
        ram2[16'h0004] = ins(8'hFF, 24'h0);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_do", rdo, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_we", we, 0);
        chk("rst_pc", pc, 0);
        rst = 1'b0;

        // SETDO/DELAY timing
        track = 8'h5A;
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0000, 100);
        chk("t1_busy_cycles", n_cyc, 16);
        chk("t1_do_5a_cycles", n_hi, 12);

        // PC wrap from 0xFFFF into address 0
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'hFFFE, 100);
        chk("wrap_busy_cycles", n_cyc, 20);
        chk("wrap_do_5a_cycles", n_hi, 12);

        // Nested loops
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0010, 200);
        chk("t2_rising_edges", n_rise, 6);
        chk("t2_busy_cycles", n_cyc, 52);

        // Loop stack overflow
        end_q.push_back({2'b01, 1'b0, 8'h00});
        go(16'h0020, 100);
        chk("ovf_busy_cycles", n_cyc, 10);

        // WAITL timeout, then trigger in 5th WAIT cycle
        end_q.push_back({2'b00, 1'b1, 8'h00});
        go(16'h0030, 100);
        chk("t3_timeout_cycles", n_cyc, 24);
        trig_at = 6;
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0030, 100);
        trig_at = -1;
        chk("t3_trigger_cycles", n_cyc, 9);

        // PMT gate of 100 cycles with 37 pulses
        pmt_lo = 10; pmt_hi = 46;
        wr_q.push_back('{16'h0200, 32'd37});
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0040, 300);
        pmt_lo = -1; pmt_hi = -2;
        chk("t4_busy_cycles", n_cyc, 106);
        chk("t4_ram_0x200", ram[16'h0200], 37);

        // DELAY lengths 2, 0, 3
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0050, 100);
        chk("delay_short_cycles", n_cyc, 9);

        // JMP skips the SETDO 0xFF
        end_q.push_back({2'b00, 1'b0, 8'h00});
        go(16'h0060, 100);
        chk("jmp_busy_cycles", n_cyc, 4);

        // Stop and start together during a long DELAY
        end_q.push_back({2'b00, 1'b0, 8'h3C});
        @(negedge clk);
        start_addr = 16'h0080; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_busy_in_delay", busy, 1);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t5_idle_after_stop", busy, 0);
        chk("t5_do_held", rdo, 8'h3C);
        repeat (2) @(negedge clk);
        chk("t5_stays_idle", busy, 0);

        // ENDL underflow and illegal opcode
        end_q.push_back({2'b10, 1'b0, 8'h3C});
        go(16'h0090, 50);
        chk("endl_busy_cycles", n_cyc, 2);
        end_q.push_back({2'b11, 1'b0, 8'h3C});
        go(16'h00A0, 50);
        repeat (3) @(negedge clk);
        chk("err_holds", err, 2'b11);
        end_q.push_back({2'b00, 1'b0, 8'h3C});
        go(16'h00A8, 50);

`ifdef PPSEQ_DEBUG_STEP_EN
        dbg = 1'b1;
        end_q.push_back({2'b00, 1'b0, 8'h3C});
        @(negedge clk);
        start_addr = 16'h00B0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("step_hold_pc0", pc, 16'h00B1);
        chk("step_hold_busy", busy, 1);
        for (int k = 1; k <= 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (5) @(negedge clk);
            chk("step_pc_advance", pc, 16'h00B1 + 16'(k));
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        chk("step_stop_idle", busy, 0);
        dbg = 1'b0;
`endif

        // Narrow accumulator saturation and single-entry loop stack
        wr2_q.push_back('{16'h0005, 32'd15});
        end2_q.push_back({2'b01, 1'b0, 8'h00});
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        i = 0;
        while (busy2 && i < 200) begin
            pmt2 = (i >= 2 && i <= 21);
            i++;
            @(negedge clk);
        end
        pmt2 = 1'b0;
        chk("dut2_busy_cycles", i, 38);
        chk("dut2_ram_5", ram2[16'h0005], 15);

        // Asynchronous reset in the middle of a program
        @(negedge clk);
        start_addr = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_pre_do", rdo, 8'h5A);
        #2 rst = 1'b1;
        #1;
        chk("midrst_do", rdo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", pc, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("wr_q_drained", wr_q.size(), 0);
        chk("end_q_drained", end_q.size(), 0);
        chk("wr2_q_drained", wr2_q.size(), 0);
        chk("end2_q_drained", end2_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
